// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: op encoding, iterative
// MixColumns FSM states and byte/GF(2^8) helper functions.
package aes_pkg;

    localparam int AES_OP_WIDTH = 2;

    typedef enum logic [AES_OP_WIDTH-1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } aes_op_e;

    // One-hot style sparse encoding; unknown codes recover to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        DONE = 3'b100
    } aes_mc_iter_state_e;

    // Swap row-major <-> column-major byte order of a 4x4 state.
    function automatic logic [127:0] aes_transpose(
        input logic [127:0] d
    );
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[8*(4*c+r) +: 8] = d[8*(4*r+c) +: 8];
            end
        end
        return t;
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] aes_mul2(
        input logic [7:0] b
    );
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational single-column MixColumns / InvMixColumns mixer.
// Ports: op_i (CIPH_FWD = forward, else inverse), data_i/data_o
// one column, row r at bits [8r+:8].
module aes_mix_single_column
    import aes_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = data_i[8*r +: 8];
            x2[r] = aes_mul2(a[r]);
            x4[r] = aes_mul2(x2[r]);
            x8[r] = aes_mul2(x4[r]);
        end
    end

    always_comb begin
        data_o = '0;
        for (int r = 0; r < 4; r++) begin
            if (op_i == CIPH_FWD) begin
                // 2a0 ^ 3a1 ^ a2 ^ a3, rotated per row
                data_o[8*r +: 8] = x2[r]
                    ^ x2[(r+1)%4] ^ a[(r+1)%4]
                    ^ a[(r+2)%4]
                    ^ a[(r+3)%4];
            end else begin
                // 14a0 ^ 11a1 ^ 13a2 ^ 9a3, rotated per row
                data_o[8*r +: 8] =
                    (x8[r] ^ x4[r] ^ x2[r])
                    ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                    ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                    ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end
        end
    end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns engine: ColsPerCycle columns per clock.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o, op_i, data_i,
// out_valid_o/out_ready_i, data_o (row-major), busy_o.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int ColsPerCycle = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   op_i,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int NumBeats = 4 / ColsPerCycle;
    localparam int BeatW = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    if (!(ColsPerCycle == 1 || ColsPerCycle == 2 ||
          ColsPerCycle == 4)) begin : g_bad_cfg
        $error("ColsPerCycle must be 1, 2 or 4");
    end

    aes_mc_iter_state_e state_q;
    logic [BeatW-1:0]   beat_q;
    logic [127:0]       work_q;
    aes_op_e            op_q;

    logic [1:0]   col_idx [ColsPerCycle];
    logic [31:0]  col_in  [ColsPerCycle];
    logic [31:0]  col_out [ColsPerCycle];
    logic [127:0] work_mixed;

    // Working register is column-major, so column c is [32c+:32].
    always_comb begin
        for (int g = 0; g < ColsPerCycle; g++) begin
            col_idx[g] = 2'(int'(beat_q) * ColsPerCycle + g);
            col_in[g]  = work_q[32*col_idx[g] +: 32];
        end
    end

    for (genvar g = 0; g < ColsPerCycle; g++) begin : g_mix
        aes_mix_single_column u_mix (
            .op_i   (op_q),
            .data_i (col_in[g]),
            .data_o (col_out[g])
        );
    end

    always_comb begin
        work_mixed = work_q;
        for (int g = 0; g < ColsPerCycle; g++) begin
            work_mixed[32*col_idx[g] +: 32] = col_out[g];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            op_q        <= CIPH_FWD;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            data_o      <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        work_q     <= aes_transpose(data_i);
                        op_q       <= aes_op_e'(op_i);
                        beat_q     <= '0;
                        state_q    <= BUSY;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                BUSY: begin
                    work_q <= work_mixed;
                    if (beat_q == BeatW'(NumBeats - 1)) begin
                        beat_q      <= '0;
                        state_q     <= DONE;
                        out_valid_o <= 1'b1;
                        // Includes this cycle's columns.
                        data_o <= aes_transpose(work_mixed);
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    beat_q      <= '0;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
